im_fetch_responder: RTL and testbench

IM_FETCH_RESPONDER -- requirements
Module: im_fetch_responder

---
 rtl/im_fetch_responder.sv | 175 +++++++++++++++++
 tb/tb_im_fetch_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_responder.sv
// Instruction-memory fetch responder.
// A word-addressed instruction store is read in a single registered stage (s1)
// whose result always drains into a 3-entry response FIFO. Request acceptance
// is throttled from registered occupancy only, so the FIFO can never overflow
// and req_ready never depends combinationally on rsp_ready or req_valid.
// The store itself has no reset; it is filled through the ld_* port.
module im_fetch_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [9:0]  ld_index,
    input  logic [31:0] ld_data
);

    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) * 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } rsp_t;

    localparam rsp_t RSP_ZERO = '{instr: 32'h0000_0000, addr: 32'h0000_0000, err: 1'b0};

    // Advance a FIFO pointer over the three slots, wrapping 2 -> 0.
    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        logic [1:0] nxt;
        case (ptr)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Instruction store (intentionally not reset)
    logic [31:0] store_q [DEPTH_WORDS];

    // Read stage
    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_addr_q,  s1_addr_d;
    logic        s1_err_q,   s1_err_d;
    logic [31:0] s1_data_q,  s1_data_d;

    // Response FIFO
    rsp_t        fifo_q [3];
    rsp_t        fifo_d [3];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q,  count_d;

    // Combinational helpers
    logic [31:0] offset_s;
    logic        req_err_s;
    logic [9:0]  word_idx_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic [2:0]  occupancy_s;
    rsp_t        head_s;

    // Address decode, handshakes and occupancy-based flow control
    always_comb begin
        offset_s    = req_addr - BASE_ADDR;
        req_err_s   = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                      (offset_s >= SPAN_BYTES);
        word_idx_s  = offset_s[11:2];
        occupancy_s = {2'b00, s1_valid_q} + {1'b0, count_q};
        req_ready   = (occupancy_s < 3'd3);
        rsp_valid   = (count_q != 2'd0);
        accept_s    = req_valid & req_ready;
        pop_s       = rsp_valid & rsp_ready;
        push_s      = s1_valid_q;
        head_s      = fifo_q[rd_ptr_q];
        if (rsp_valid) begin
            rsp_instr = head_s.instr;
            rsp_addr  = head_s.addr;
            rsp_err   = head_s.err;
        end else begin
            rsp_instr = 32'h0000_0000;
            rsp_addr  = 32'h0000_0000;
            rsp_err   = 1'b0;
        end
    end

    // Next state of the read stage; errored requests skip the store read
    always_comb begin
        s1_valid_d = 1'b0;
        s1_addr_d  = s1_addr_q;
        s1_err_d   = s1_err_q;
        s1_data_d  = s1_data_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = req_addr;
            s1_err_d   = req_err_s;
            if (!req_err_s) begin
                s1_data_d = store_q[word_idx_s];
            end else begin
                s1_data_d = 32'h0000_0000;
            end
        end else begin
            s1_valid_d = 1'b0;
        end
    end

    // Next state of the response FIFO: s1 always pushes, consumer pops
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = '{instr: s1_data_q, addr: s1_addr_q, err: s1_err_q};
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pipeline and FIFO state registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= 32'h0000_0000;
            s1_err_q   <= 1'b0;
            s1_data_q  <= 32'h0000_0000;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= RSP_ZERO;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_err_q   <= s1_err_d;
            s1_data_q  <= s1_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    // Store load port; a same-edge fetch of this index sees the old word
    always_ff @(posedge clk) begin
        if (ld_en) begin
            store_q[ld_index] <= ld_data;
        end
    end

endmodule

// File: tb/tb_im_fetch_responder.sv
// Self-checking bench for im_fetch_responder. Inputs change on the falling
// edge, outputs are sampled on the falling edge; expected responses are
// queued when a request is seen accepted and compared when they emerge.
module tb_im_fetch_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        ld_en;
    logic [9:0]  ld_index;
    logic [31:0] ld_data;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    logic [31:0] model_mem [1024];

    im_fetch_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_index  (ld_index),
        .ld_data   (ld_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference response for a request with default BASE_ADDR/DEPTH_WORDS.
    function automatic exp_t predict(input logic [31:0] a);
        exp_t        r;
        logic [31:0] off;
        off     = a - 32'h0000_3000;
        r.addr  = a;
        r.err   = (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (off >= 32'h0000_1000);
        r.instr = r.err ? 32'h0000_0000 : model_mem[off[11:2]];
        return r;
    endfunction

    task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_en    = 1'b1;
        ld_index = idx;
        ld_data  = data;
        model_mem[idx] = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_index = 10'h0; ld_data = 32'h0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_instr !== 32'h0) begin errors++; $display("FAIL reset_rsp_instr: got %h want 0", rsp_instr); end
        checks++; if (rsp_addr !== 32'h0) begin errors++; $display("FAIL reset_rsp_addr: got %h want 0", rsp_addr); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        repeat (2) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_hold: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        exp_t e;
        load_word(10'd0, 32'h3C01_1234);
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_3000;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_early: rsp_valid=%b want 0 one edge after accept", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: rsp_valid=%b want 1 two edges after accept", rsp_valid); end
        e = '{instr: 32'h3C01_1234, addr: 32'h0000_3000, err: 1'b0};
        checks++; if ({rsp_instr, rsp_addr, rsp_err} !== e) begin
            errors++; $display("FAIL basic_data: got %h/%h/%b want %h/%h/%b", rsp_instr, rsp_addr, rsp_err, e.instr, e.addr, e.err);
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_pop: rsp_valid=%b want 0 after pop", rsp_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        exp_t        exps [4];
        exp_t        e;
        int          sent = 0;
        load_word(10'd1023, 32'h600D_F00D);
        addrs[0] = 32'h0000_3002; exps[0] = '{instr: 32'h0, addr: 32'h0000_3002, err: 1'b1};
        addrs[1] = 32'h0000_2FFC; exps[1] = '{instr: 32'h0, addr: 32'h0000_2FFC, err: 1'b1};
        addrs[2] = 32'h0000_4000; exps[2] = '{instr: 32'h0, addr: 32'h0000_4000, err: 1'b1};
        addrs[3] = 32'h0000_3FFC; exps[3] = '{instr: 32'h600D_F00D, addr: 32'h0000_3FFC, err: 1'b0};
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && !(sent == 4 && exp_q.size() == 0); c++) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL err_extra: unexpected response addr=%h", rsp_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_instr, rsp_addr, rsp_err} !== e) begin
                        errors++; $display("FAIL err_resp: got %h/%h/%b want %h/%h/%b", rsp_instr, rsp_addr, rsp_err, e.instr, e.addr, e.err);
                    end
                end
            end
            if (sent < 4) begin
                req_valid = 1'b1; req_addr = addrs[sent];
                if (req_ready === 1'b1) begin exp_q.push_back(exps[sent]); sent++; end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (exp_q.size() != 0 || sent != 4) begin
            errors++; $display("FAIL err_timeout: sent=%0d pending=%0d want 4/0", sent, exp_q.size());
        end
    endtask

    task automatic test_streaming();
        exp_t e;
        int   sent = 0, got = 0, gaps = 0;
        logic first_seen = 1'b0;
        for (int i = 0; i < 8; i++) load_word(10'(i), 32'h5EED_0000 + 32'(i * 17));
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && !(sent == 8 && exp_q.size() == 0); c++) begin
            if (rsp_valid === 1'b1) begin
                first_seen = 1'b1; got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra: unexpected response addr=%h", rsp_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_instr, rsp_addr, rsp_err} !== e) begin
                        errors++; $display("FAIL stream_resp: got %h/%h/%b want %h/%h/%b", rsp_instr, rsp_addr, rsp_err, e.instr, e.addr, e.err);
                    end
                end
            end else if (first_seen && got < 8) begin
                gaps++;
            end
            if (sent < 8) begin
                req_valid = 1'b1; req_addr = 32'h0000_3000 + 32'(sent * 4);
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++; $display("FAIL stream_stall: req_ready=%b want 1 at request %0d", req_ready, sent);
                end else begin
                    exp_q.push_back(predict(req_addr)); sent++;
                end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (got != 8 || gaps != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL stream_summary: got=%0d gaps=%0d pending=%0d want 8/0/0", got, gaps, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        int          accepted = 0;
        logic        head_seen = 1'b0;
        logic [31:0] head_instr = 32'h0, head_addr = 32'h0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid === 1'b1 && !head_seen) begin
                head_seen = 1'b1; head_instr = rsp_instr; head_addr = rsp_addr;
            end
            req_valid = 1'b1; req_addr = 32'h0000_3000 + 32'(accepted * 4);
            if (req_ready === 1'b1) begin exp_q.push_back(predict(req_addr)); accepted++; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (accepted != 3) begin errors++; $display("FAIL bp_accepted: got %0d want 3", accepted); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0 when full", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_instr !== head_instr || rsp_addr !== head_addr) begin
            errors++; $display("FAIL bp_head_stable: got %b/%h/%h want 1/%h/%h", rsp_valid, rsp_instr, rsp_addr, head_instr, head_addr);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (rsp_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if ({rsp_instr, rsp_addr, rsp_err} !== e) begin
                    errors++; $display("FAIL bp_resp: got %h/%h/%b want %h/%h/%b", rsp_instr, rsp_addr, rsp_err, e.instr, e.addr, e.err);
                end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout: pending=%0d want 0", exp_q.size()); end
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drained: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_read_before_write();
        exp_t e;
        load_word(10'd5, 32'hAAAA_AAAA);
        rsp_ready = 1'b1;
        ld_en = 1'b1; ld_index = 10'd5; ld_data = 32'h5555_5555;
        req_valid = 1'b1; req_addr = 32'h0000_3014;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rbw_ready: got %b want 1", req_ready); end
        exp_q.push_back('{instr: 32'hAAAA_AAAA, addr: 32'h0000_3014, err: 1'b0});
        model_mem[5] = 32'h5555_5555;
        @(negedge clk);
        ld_en = 1'b0;
        exp_q.push_back('{instr: 32'h5555_5555, addr: 32'h0000_3014, err: 1'b0});
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (rsp_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if ({rsp_instr, rsp_addr, rsp_err} !== e) begin
                    errors++; $display("FAIL rbw_resp: got %h/%h/%b want %h/%h/%b", rsp_instr, rsp_addr, rsp_err, e.instr, e.addr, e.err);
                end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rbw_timeout: pending=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midop();
        int accepted = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req_valid = (accepted < 3); req_addr = 32'h0000_3000 + 32'(accepted * 4);
            if (req_valid && req_ready === 1'b1) accepted++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_full: rsp_valid=%b req_ready=%b want 1/0", rsp_valid, req_ready);
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_async: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
        checks++; if (rsp_instr !== 32'h0 || rsp_addr !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got %h/%h/%b want 0/0/0", rsp_instr, rsp_addr, rsp_err);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_3014;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_early: rsp_valid=%b want 0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h5555_5555 || rsp_addr !== 32'h0000_3014 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL midrst_store_kept: got %b/%h/%h/%b want 1/55555555/00003014/0", rsp_valid, rsp_instr, rsp_addr, rsp_err);
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_pop: rsp_valid=%b want 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_streaming();
        test_backpressure();
        test_read_before_write();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
